// File: rtl/board_state_mem.sv
// Board cell store: a game-side write port with accept/reject handshake, a registered
// display-side read port, and a full-board clear sweep.
module board_state_mem #(
  parameter int CELLS = 100,
  parameter int COLS  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] rd_addr,
  output logic [1:0] rd_data,
  input  logic       wr_req,
  input  logic [6:0] wr_addr,
  input  logic [1:0] wr_data,
  output logic       wr_ack,
  output logic       wr_nak,
  input  logic       clr_req,
  output logic       busy,
  output logic [6:0] occupied,
  output logic       full,
  output logic [4:0] last_x,
  output logic [4:0] last_y
);

  typedef enum logic [1:0] {IDLE, CHECK, RESP, CLEAR} state_t;

  state_t     state;
  logic [1:0] cells [CELLS];
  logic [6:0] req_addr;
  logic [1:0] req_data;
  logic [6:0] clr_idx;

  logic       req_in_range;
  logic [1:0] req_cell;
  logic       req_ok;
  logic       commit_we;
  logic       clear_we;

  assign req_in_range = (req_addr < 7'(CELLS));
  assign req_cell     = req_in_range ? cells[req_addr] : 2'b00;
  assign req_ok       = req_in_range && (req_data != 2'b00) && (req_cell == 2'b00);
  // wr_ack is registered on entry to RESP, so it doubles as the commit qualifier.
  assign commit_we    = (state == RESP) && wr_ack;
  assign clear_we     = (state == CLEAR);
  assign full         = (occupied == 7'(CELLS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= 2'b00;
    end else if (clear_we) begin
      cells[clr_idx] <= 2'b00;
    end else if (commit_we) begin
      cells[req_addr] <= req_data;
    end
  end

  // Read port runs regardless of FSM state; a same-edge commit is not forwarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= 2'b00;
    end else begin
      rd_data <= (rd_addr < 7'(CELLS)) ? cells[rd_addr] : 2'b00;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      req_addr <= '0;
      req_data <= '0;
      clr_idx  <= '0;
      wr_ack   <= 1'b0;
      wr_nak   <= 1'b0;
      busy     <= 1'b0;
      occupied <= '0;
      last_x   <= '0;
      last_y   <= '0;
    end else begin
      wr_ack <= 1'b0;
      wr_nak <= 1'b0;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            busy    <= 1'b1;
            clr_idx <= '0;
          end else if (wr_req) begin
            req_addr <= wr_addr;
            req_data <= wr_data;
            state    <= CHECK;
          end
        end
        CHECK: begin
          wr_ack <= req_ok;
          wr_nak <= !req_ok;
          state  <= RESP;
        end
        RESP: begin
          if (wr_ack) begin
            if (occupied != 7'(CELLS)) occupied <= occupied + 7'd1;
            last_x <= 5'(req_addr % 7'(COLS));
            last_y <= 5'(req_addr / 7'(COLS));
          end
          state <= IDLE;
        end
        CLEAR: begin
          if (clr_idx == 7'(CELLS - 1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            occupied <= '0;
            last_x   <= '0;
            last_y   <= '0;
          end else begin
            clr_idx <= clr_idx + 7'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_state_mem.sv
// Self-checking bench for board_state_mem: scenario tasks with a reference board model
// and scoreboard queues for write responses and read data.
module tb_board_state_mem;

  logic       clk;
  logic       rst;
  logic [6:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_req;
  logic [6:0] wr_addr;
  logic [1:0] wr_data;
  logic       wr_ack;
  logic       wr_nak;
  logic       clr_req;
  logic       busy;
  logic [6:0] occupied;
  logic       full;
  logic [4:0] last_x;
  logic [4:0] last_y;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] model [100];
  int         m_occ, m_lx, m_ly;
  bit         exp_q [$];
  logic [1:0] rd_q  [$];

  board_state_mem #(.CELLS(100), .COLS(10)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ack(wr_ack), .wr_nak(wr_nak), .clr_req(clr_req), .busy(busy),
    .occupied(occupied), .full(full), .last_x(last_x), .last_y(last_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 100; i++) model[i] = 2'b00;
    m_occ = 0;
    m_lx  = 0;
    m_ly  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; rd_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++; if (rd_data !== 2'b00) begin n_errors++; $display("FAIL reset_rd_data got %b exp 00", rd_data); end
    n_checks++; if (wr_ack !== 1'b0 || wr_nak !== 1'b0) begin n_errors++; $display("FAIL reset_ack_nak got %b%b exp 00", wr_ack, wr_nak); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (occupied !== 7'd0 || full !== 1'b0) begin n_errors++; $display("FAIL reset_occupied got %0d/%b exp 0/0", occupied, full); end
    n_checks++; if (last_x !== 5'd0 || last_y !== 5'd0) begin n_errors++; $display("FAIL reset_last got %0d,%0d exp 0,0", last_x, last_y); end
    rst = 1'b0;
    $display("reset: released");
  endtask

  task automatic test_write(input logic [6:0] addr, input logic [1:0] data, input string tag);
    bit exp_ack, got_ack, got_nak, e;
    int lat;
    exp_ack = 1'b0;
    if (addr < 7'd100 && data != 2'b00) exp_ack = (model[addr] == 2'b00);
    exp_q.push_back(exp_ack);
    if (exp_ack) begin
      model[addr] = data;
      m_occ++;
      m_lx = int'(addr) % 10;
      m_ly = int'(addr) / 10;
    end
    wr_addr = addr; wr_data = data; wr_req = 1'b1;
    lat = 0; got_ack = 1'b0; got_nak = 1'b0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (wr_ack === 1'b1 || wr_nak === 1'b1) begin
        got_ack = (wr_ack === 1'b1);
        got_nak = (wr_nak === 1'b1);
        break;
      end
    end
    wr_req = 1'b0;
    e = exp_q.pop_front();
    n_checks++; if (!(got_ack || got_nak) || lat != 2) begin n_errors++; $display("FAIL %s latency got %0d exp 2", tag, lat); end
    n_checks++; if (got_ack != e || got_nak != !e) begin n_errors++; $display("FAIL %s response got ack=%b nak=%b exp ack=%b", tag, got_ack, got_nak, e); end
    @(negedge clk);
    n_checks++; if (wr_ack !== 1'b0 || wr_nak !== 1'b0) begin n_errors++; $display("FAIL %s extra_pulse got %b%b exp 00", tag, wr_ack, wr_nak); end
    n_checks++; if (occupied !== 7'(m_occ)) begin n_errors++; $display("FAIL %s occupied got %0d exp %0d", tag, occupied, m_occ); end
    n_checks++; if (full !== (m_occ == 100)) begin n_errors++; $display("FAIL %s full got %b exp %b", tag, full, (m_occ == 100)); end
    n_checks++; if (last_x !== 5'(m_lx) || last_y !== 5'(m_ly)) begin n_errors++; $display("FAIL %s last got %0d,%0d exp %0d,%0d", tag, last_x, last_y, m_lx, m_ly); end
    $display("write %s addr=%0d data=%b -> ack=%b nak=%b lat=%0d occ=%0d", tag, addr, data, got_ack, got_nak, lat, occupied);
  endtask

  task automatic test_readback(input string tag);
    logic [6:0] a;
    logic [1:0] e;
    int bad;
    bad = 0;
    for (int i = 0; i < 103; i++) begin
      a = (i < 100) ? 7'(i) : (i == 100) ? 7'd100 : (i == 101) ? 7'd127 : 7'd64;
      rd_addr = a;
      rd_q.push_back((a < 7'd100) ? model[a] : 2'b00);
      @(negedge clk);
      e = rd_q.pop_front();
      n_checks++;
      if (rd_data !== e) begin
        n_errors++; bad++;
        $display("FAIL %s read addr=%0d got %b exp %b", tag, a, rd_data, e);
      end
    end
    $display("readback %s: 103 reads, %0d bad", tag, bad);
  endtask

  task automatic test_basic();
    test_write(7'd23, 2'b01, "basic_23");
    test_readback("after_basic");
  endtask

  task automatic test_reject();
    test_write(7'd23, 2'b10, "rewrite_23");
    test_write(7'd100, 2'b01, "addr_100");
    test_write(7'd127, 2'b11, "addr_127");
    test_write(7'd5, 2'b00, "data_00");
    test_readback("after_reject");
  endtask

  task automatic test_same_cycle_read();
    bit e;
    e = (model[45] == 2'b00);
    exp_q.push_back(e);
    wr_addr = 7'd45; wr_data = 2'b10; wr_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rd_addr = 7'd45;
    wr_req = 1'b0;
    n_checks++; if (wr_ack !== exp_q.pop_front()) begin n_errors++; $display("FAIL same_cycle ack got %b exp %b", wr_ack, e); end
    if (e) begin model[45] = 2'b10; m_occ++; m_lx = 5; m_ly = 4; end
    @(negedge clk);
    n_checks++; if (rd_data !== 2'b00) begin n_errors++; $display("FAIL same_cycle old_value got %b exp 00", rd_data); end
    @(negedge clk);
    n_checks++; if (rd_data !== 2'b10) begin n_errors++; $display("FAIL same_cycle new_value got %b exp 10", rd_data); end
    $display("same_cycle_read addr=45 ack=%b rd=%b", e, rd_data);
  endtask

  task automatic test_reset_mid_write();
    int bad;
    wr_addr = 7'd50; wr_data = 2'b11; wr_req = 1'b1;
    @(negedge clk);
    rst = 1'b1; wr_req = 1'b0;
    #1;
    n_checks++; if (wr_ack !== 1'b0 || wr_nak !== 1'b0 || occupied !== 7'd0) begin n_errors++; $display("FAIL mid_write_reset got %b%b occ=%0d exp 00 occ=0", wr_ack, wr_nak, occupied); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wr_ack !== 1'b0 || wr_nak !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL mid_write_no_pulse got %0d bad cycles exp 0", bad); end
    $display("reset_mid_write: aborted, %0d bad cycles", bad);
    test_write(7'd50, 2'b11, "after_mid_reset");
  endtask

  task automatic test_fill_and_clear();
    int cnt;
    for (int a = 0; a < 100; a++) if (model[a] == 2'b00) test_write(7'(a), 2'b01, "fill");
    test_write(7'd0, 2'b10, "write_101");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 300) begin
      cnt++;
      if (cnt == 20) clr_req = 1'b1;
      if (cnt == 21) clr_req = 1'b0;
      if (cnt == 50) rd_addr = 7'd10;
      if (cnt == 51) begin
        n_checks++; if (rd_data !== 2'b00) begin n_errors++; $display("FAIL clear_partial_low got %b exp 00", rd_data); end
        rd_addr = 7'd90;
      end
      if (cnt == 52) begin
        n_checks++; if (rd_data !== model[90]) begin n_errors++; $display("FAIL clear_partial_high got %b exp %b", rd_data, model[90]); end
      end
      @(negedge clk);
    end
    n_checks++; if (cnt != 100) begin n_errors++; $display("FAIL clear_busy_cycles got %0d exp 100", cnt); end
    n_checks++; if (occupied !== 7'd0 || full !== 1'b0) begin n_errors++; $display("FAIL clear_occupied got %0d/%b exp 0/0", occupied, full); end
    n_checks++; if (last_x !== 5'd0 || last_y !== 5'd0) begin n_errors++; $display("FAIL clear_last got %0d,%0d exp 0,0", last_x, last_y); end
    $display("clear: busy for %0d cycles, occ=%0d", cnt, occupied);
    model_reset();
    test_readback("after_clear");
  endtask

  task automatic test_clr_priority();
    int lat, busy_cnt;
    bit got_ack, got_nak, e;
    exp_q.push_back(1'b1);
    clr_req = 1'b1;
    wr_addr = 7'd7; wr_data = 2'b10; wr_req = 1'b1;
    lat = 0; busy_cnt = 0; got_ack = 1'b0; got_nak = 1'b0;
    while (lat < 400) begin
      @(negedge clk);
      lat++;
      if (lat == 1) clr_req = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (wr_ack === 1'b1 || wr_nak === 1'b1) begin
        got_ack = (wr_ack === 1'b1);
        got_nak = (wr_nak === 1'b1);
        break;
      end
    end
    wr_req = 1'b0;
    e = exp_q.pop_front();
    model[7] = 2'b10; m_occ = 1; m_lx = 7; m_ly = 0;
    n_checks++; if (lat != 103) begin n_errors++; $display("FAIL clr_priority latency got %0d exp 103", lat); end
    n_checks++; if (busy_cnt != 100) begin n_errors++; $display("FAIL clr_priority busy_cycles got %0d exp 100", busy_cnt); end
    n_checks++; if (got_ack != e || got_nak) begin n_errors++; $display("FAIL clr_priority response got ack=%b nak=%b exp ack=1", got_ack, got_nak); end
    @(negedge clk);
    n_checks++; if (occupied !== 7'(m_occ) || last_x !== 5'(m_lx) || last_y !== 5'(m_ly)) begin n_errors++; $display("FAIL clr_priority state got occ=%0d last=%0d,%0d exp 1 7,0", occupied, last_x, last_y); end
    $display("clr_priority: ack after %0d cycles, busy %0d cycles, occ=%0d", lat, busy_cnt, occupied);
    test_readback("after_priority");
  endtask

  task automatic test_reset_mid_clear();
    int cnt, bad;
    test_write(7'd60, 2'b11, "pre_clear_60");
    test_write(7'd99, 2'b01, "pre_clear_99");
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    cnt = 0;
    for (int k = 1; k <= 51; k++) begin
      if (k > 1) @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    n_checks++; if (cnt != 51) begin n_errors++; $display("FAIL mid_clear_busy got %0d exp 51", cnt); end
    rst = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL mid_clear_reset_busy got %b exp 0", busy); end
    n_checks++; if (occupied !== 7'd0 || rd_data !== 2'b00 || last_x !== 5'd0 || last_y !== 5'd0) begin n_errors++; $display("FAIL mid_clear_reset_state got occ=%0d rd=%b last=%0d,%0d exp 0", occupied, rd_data, last_x, last_y); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (wr_ack !== 1'b0 || wr_nak !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL mid_clear_no_pulse got %0d bad cycles exp 0", bad); end
    $display("reset_mid_clear: reset at sweep index 50, %0d bad cycles", bad);
    test_readback("after_mid_clear_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_same_cycle_read();
    test_reset_mid_write();
    test_fill_and_clear();
    test_clr_priority();
    test_reset_mid_clear();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
